// File: rtl/conv_t1d_pkg.sv
// Shared types and default widths for the dilated transposed-1D conv sequencer.
package conv_t1d_pkg;

   localparam int IDX_W_DEF = 16;
   localparam int OUT_W_DEF = 24;
   localparam int K_W_DEF   = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] in_idx;
      logic [K_W_DEF-1:0]   k_idx;
      logic [OUT_W_DEF-1:0] out_idx;
   } cmd_t;

endpackage

// File: rtl/conv_t1d_idx_gen.sv
// Walks (i,k) with k innermost and tracks o = i*S - P + k*D using adds only.
module conv_t1d_idx_gen import conv_t1d_pkg::*; #(
   parameter int IDX_W = IDX_W_DEF,
   parameter int K_W   = K_W_DEF,
   parameter int SW    = 26
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init,
   input  logic                 adv,
   input  logic [IDX_W-1:0]     len_in,
   input  logic [K_W-1:0]       kernel,
   input  logic [3:0]           stride,
   input  logic [3:0]           dilation,
   input  logic [IDX_W-1:0]     padding,
   output logic [IDX_W-1:0]     i_idx,
   output logic [K_W-1:0]       k_idx,
   output logic signed [SW-1:0] o_idx,
   output logic                 last
);

   logic signed [SW-1:0] base_q, neg_pad, s_ext, d_ext;
   logic                 k_wrap;

   assign neg_pad = -$signed(SW'(padding));
   assign s_ext   = $signed(SW'(stride));
   assign d_ext   = $signed(SW'(dilation));
   assign k_wrap  = (k_idx == kernel - K_W'(1));
   assign last    = k_wrap && (i_idx == len_in - IDX_W'(1));

   // base_q holds i*S - P so a row wrap restarts o without a multiply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_idx  <= '0;
         k_idx  <= '0;
         o_idx  <= '0;
         base_q <= '0;
      end else if (init) begin
         i_idx  <= '0;
         k_idx  <= '0;
         o_idx  <= neg_pad;
         base_q <= neg_pad;
      end else if (adv) begin
         if (k_wrap) begin
            k_idx  <= '0;
            i_idx  <= i_idx + IDX_W'(1);
            base_q <= base_q + s_ext;
            o_idx  <= base_q + s_ext;
         end else begin
            k_idx <= k_idx + K_W'(1);
            o_idx <= o_idx + d_ext;
         end
      end
   end

endmodule

// File: rtl/conv_t1d_dil_seq.sv
// Dilated transposed-1D conv MAC-command sequencer (IDLE->SETUP->RUN->DONE).
// Optional CONV_T1D_SEQ_STATS_EN adds issued/skipped saturating counters.
module conv_t1d_dil_seq import conv_t1d_pkg::*; #(
   parameter int IDX_W = IDX_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int K_W   = K_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] cfg_len_in,
   input  logic [K_W-1:0]   cfg_kernel,
   input  logic [3:0]       cfg_stride,
   input  logic [3:0]       cfg_dilation,
   input  logic [IDX_W-1:0] cfg_padding,
   output logic             busy,
   output logic             done,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [IDX_W-1:0] cmd_in_idx,
   output logic [K_W-1:0]   cmd_k_idx,
   output logic [OUT_W-1:0] cmd_out_idx
`ifdef CONV_T1D_SEQ_STATS_EN
   ,
   output logic [15:0]      stat_issued,
   output logic [15:0]      stat_skipped
`endif
);

   localparam int SW_A = (IDX_W > K_W) ? IDX_W : K_W;
   localparam int SW   = (SW_A + 7 > OUT_W + 2) ? SW_A + 7 : OUT_W + 2;
   localparam logic signed [SW-1:0] ONE = SW'(1);

   state_t               state_q, state_d;
   logic                 setup_ph;
   logic [IDX_W-1:0]     len_q, pad_q;
   logic [K_W-1:0]       k_q;
   logic [3:0]           s_q, d_q;
   logic signed [SW-1:0] len_s, k_s, s_s, d_s, p_s, l_out_c, l_out_q, o_idx;
   logic                 lout_pos, in_range, adv, skip, last;

   assign len_s = $signed(SW'(len_q));
   assign k_s   = $signed(SW'(k_q));
   assign s_s   = $signed(SW'(s_q));
   assign d_s   = $signed(SW'(d_q));
   assign p_s   = $signed(SW'(pad_q));
   // multiplies live only in the first SETUP cycle and are registered
   assign l_out_c  = (len_s - ONE) * s_s - (p_s + p_s) + d_s * (k_s - ONE) + ONE;
   assign lout_pos = !l_out_q[SW-1] && (l_out_q != '0);
   assign in_range = !o_idx[SW-1] && (o_idx < l_out_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         setup_ph <= 1'b0;
         len_q    <= '0;
         pad_q    <= '0;
         k_q      <= '0;
         s_q      <= '0;
         d_q      <= '0;
         l_out_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            len_q    <= cfg_len_in;
            pad_q    <= cfg_padding;
            k_q      <= cfg_kernel;
            s_q      <= (cfg_stride == 4'd0) ? 4'd1 : cfg_stride;
            d_q      <= (cfg_dilation == 4'd0) ? 4'd1 : cfg_dilation;
            setup_ph <= 1'b0;
         end
         if (state_q == ST_SETUP) begin
            setup_ph <= 1'b1;
            if (!setup_ph) l_out_q <= l_out_c;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      cmd_valid = 1'b0;
      adv       = 1'b0;
      skip      = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SETUP;
         ST_SETUP: begin
            busy = 1'b1;
            if (setup_ph)
               state_d = (len_q == '0 || k_q == '0 || !lout_pos) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            busy      = 1'b1;
            cmd_valid = in_range;
            skip      = !in_range;
            adv       = !in_range || cmd_ready;
            if (adv && last) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   conv_t1d_idx_gen #(.IDX_W(IDX_W), .K_W(K_W), .SW(SW)) u_idx_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (state_q == ST_SETUP),
      .adv      (adv),
      .len_in   (len_q),
      .kernel   (k_q),
      .stride   (s_q),
      .dilation (d_q),
      .padding  (pad_q),
      .i_idx    (cmd_in_idx),
      .k_idx    (cmd_k_idx),
      .o_idx    (o_idx),
      .last     (last)
   );

   assign cmd_out_idx = o_idx[OUT_W-1:0];

`ifdef CONV_T1D_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued  <= '0;
         stat_skipped <= '0;
      end else if (state_q == ST_IDLE && start) begin
         stat_issued  <= '0;
         stat_skipped <= '0;
      end else begin
         if (cmd_valid && cmd_ready && stat_issued != 16'hFFFF)
            stat_issued <= stat_issued + 16'd1;
         if (skip && stat_skipped != 16'hFFFF)
            stat_skipped <= stat_skipped + 16'd1;
      end
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule
